// File: rtl/param_def.sv
// param_def: shared rate codes, K=3 generator taps, FSM states and frame sizing
// for the convolutional encoder framer.
package param_def;
    localparam logic CODE_RATE_2 = 1'b0;
    localparam logic CODE_RATE_3 = 1'b1;
    localparam logic [2:0] GEN_A = 3'o7;
    localparam logic [2:0] GEN_B = 3'o5;
    localparam logic [2:0] GEN_C = 3'o6;
    typedef enum logic [1:0] {IDLE, ENC, FLUSH, EMIT} state_t;
    function automatic logic [3:0] frame_syms(input logic rate);
        return (rate == CODE_RATE_2) ? 4'd8 : 4'd5;
    endfunction
endpackage

// File: rtl/conv_symbol_gen.sv
// conv_symbol_gen: combinational K=3 symbol for bit b over state {s1,s0}.
// Rate 1/2 symbols sit right-aligned in o_sym[1:0] with o_sym[2]=0.
module conv_symbol_gen
    import param_def::*;
(
    input  logic       i_b,
    input  logic       i_s1,
    input  logic       i_s0,
    input  logic       i_rate,
    output logic [2:0] o_sym
);
    logic [2:0] w_reg;
    logic       w_a;
    logic       w_b;
    logic       w_c;
    assign w_reg = {i_b, i_s1, i_s0};
    assign w_a   = ^(GEN_A & w_reg);
    assign w_b   = ^(GEN_B & w_reg);
    assign w_c   = ^(GEN_C & w_reg);
    assign o_sym = (i_rate == CODE_RATE_3) ? {w_a, w_b, w_c} : {1'b0, w_a, w_b};
endmodule

// File: rtl/conv_encoder_framer.sv
// conv_encoder_framer: K=3 convolutional encoder (rate 1/2 or 1/3) that packs
// symbols MSB-first into 16-bit frames, appending two zero tail bits per message.
module conv_encoder_framer
    import param_def::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_code_rate,
    input  logic        i_bit,
    input  logic        i_bit_valid,
    input  logic        i_last,
    output logic        o_bit_ready,
    output logic [15:0] o_frame,
    output logic        o_frame_valid,
    output logic        o_frame_last,
    input  logic        i_frame_ready
);
    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_s;
    logic [1:0]  r_tail;
    logic [3:0]  r_cnt;
    logic [15:0] r_frame;
    logic        r_last;
    logic        r_rate;
    logic        w_rate;
    logic        w_accept;
    logic        w_enc;
    logic        w_b;
    logic        w_full;
    logic        w_final;
    logic [1:0]  w_tail_nxt;
    logic [3:0]  w_cnt_nxt;
    logic [4:0]  w_shift;
    logic [2:0]  w_sym;

    // Rate is taken live in IDLE and frozen by the first accepted bit.
    assign w_rate     = (r_state == IDLE) ? i_code_rate : r_rate;
    assign w_accept   = i_bit_valid & o_bit_ready;
    assign w_enc      = w_accept | (r_state == FLUSH);
    assign w_b        = (r_state == FLUSH) ? 1'b0 : i_bit;
    assign w_cnt_nxt  = r_cnt + 4'd1;
    assign w_full     = (w_cnt_nxt == frame_syms(w_rate));
    assign w_final    = (r_state == FLUSH) && (r_tail == 2'd1);
    assign w_tail_nxt = (r_state == FLUSH) ? r_tail - 2'd1 : (i_last ? 2'd2 : 2'd0);
    assign w_shift    = (w_rate == CODE_RATE_3) ? 5'd13 - 5'd3 * {1'b0, r_cnt}
                                                : 5'd14 - 5'd2 * {1'b0, r_cnt};

    conv_symbol_gen u_sym (
        .i_b    (w_b),
        .i_s1   (r_s[1]),
        .i_s0   (r_s[0]),
        .i_rate (w_rate),
        .o_sym  (w_sym)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        o_bit_ready = 1'b0;
        case (r_state)
            IDLE, ENC: begin
                o_bit_ready = 1'b1;
                if (w_accept) w_next = w_full ? EMIT : (i_last ? FLUSH : ENC);
            end
            FLUSH:   w_next = (w_full || w_final) ? EMIT : FLUSH;
            EMIT:    if (i_frame_ready) w_next = r_last ? IDLE : ((r_tail != 2'd0) ? FLUSH : ENC);
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s     <= 2'b00;
            r_tail  <= 2'd0;
            r_cnt   <= 4'd0;
            r_frame <= 16'd0;
            r_last  <= 1'b0;
            r_rate  <= CODE_RATE_2;
        end else if (w_enc) begin
            r_s     <= {w_b, r_s[1]};
            r_tail  <= w_tail_nxt;
            r_cnt   <= w_cnt_nxt;
            r_frame <= r_frame | ({13'd0, w_sym} << w_shift);
            r_last  <= w_final;
            if (r_state == IDLE) r_rate <= i_code_rate;
        end else if (r_state == EMIT && i_frame_ready) begin
            r_cnt   <= 4'd0;
            r_frame <= 16'd0;
            r_last  <= 1'b0;
        end
    end

    assign o_frame       = r_frame;
    assign o_frame_valid = (r_state == EMIT);
    assign o_frame_last  = r_last;
endmodule

// File: tb/tb_conv_encoder_framer.sv
// tb_conv_encoder_framer: directed scenarios with a frame scoreboard; expected
// frames come from spec constants or an independent bit-position encoder model.
module tb_conv_encoder_framer;
    import param_def::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_code_rate = 1'b0;
    logic        i_bit = 1'b0;
    logic        i_bit_valid = 1'b0;
    logic        i_last = 1'b0;
    logic        i_frame_ready = 1'b1;
    logic        o_bit_ready;
    logic        o_frame_valid;
    logic        o_frame_last;
    logic [15:0] o_frame;

    int          errs = 0;
    int          checks = 0;
    logic [16:0] sb[$];
    logic [1:0]  m_s = 2'b00;
    logic [15:0] m_frame = 16'd0;
    int          m_pos = 0;

    conv_encoder_framer dut (
        .clk           (clk),
        .rst           (rst),
        .i_code_rate   (i_code_rate),
        .i_bit         (i_bit),
        .i_bit_valid   (i_bit_valid),
        .i_last        (i_last),
        .o_bit_ready   (o_bit_ready),
        .o_frame       (o_frame),
        .o_frame_valid (o_frame_valid),
        .o_frame_last  (o_frame_last),
        .i_frame_ready (i_frame_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference encoder: places symbol bits by absolute bit position.
    task automatic model_bit(input logic b, input logic rate, input logic fin);
        logic [2:0] sym;
        int w;
        sym = rate ? {b ^ m_s[1] ^ m_s[0], b ^ m_s[0], b ^ m_s[1]}
                   : {1'b0, b ^ m_s[1] ^ m_s[0], b ^ m_s[0]};
        w = rate ? 3 : 2;
        for (int k = 0; k < w; k++) m_frame[15 - m_pos - k] = sym[w - 1 - k];
        m_pos += w;
        m_s = {b, m_s[1]};
        if (fin || m_pos + w > 16) begin
            sb.push_back({fin, m_frame});
            m_frame = 16'd0;
            m_pos = 0;
        end
    endtask

    task automatic send_bit(input logic b, input logic last, input logic rate);
        int t = 0;
        i_bit = b;
        i_last = last;
        i_code_rate = rate;
        i_bit_valid = 1'b1;
        while (!o_bit_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("bit_ready_wait", o_bit_ready, 1);
        @(negedge clk);
        i_bit_valid = 1'b0;
        i_last = 1'b0;
    endtask

    task automatic send_msg(input logic [63:0] bits, input int n, input logic rate,
                            input logic last, input logic flip, input logic mdl);
        if (mdl) begin
            for (int i = 0; i < n; i++) model_bit(bits[i], rate, 1'b0);
            if (last) begin
                model_bit(1'b0, rate, 1'b0);
                model_bit(1'b0, rate, 1'b1);
            end
        end
        for (int i = 0; i < n; i++) begin
            send_bit(bits[i], last && (i == n - 1), rate ^ (flip && i > 0));
            if (flip && i == 2) begin
                i_last = 1'b1;
                @(negedge clk);
                i_last = 1'b0;
            end
        end
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while (sb.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        check(tag, sb.size(), 0);
        check("idle_valid", o_frame_valid, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", o_frame_valid, 0);
        check("rst_frame", o_frame, 0);
        check("rst_last", o_frame_last, 0);
        rst = 1'b1;
        m_s = 2'b00;
        m_frame = 16'd0;
        m_pos = 0;
        @(negedge clk);
        check("rst_bit_ready", o_bit_ready, 1);
    endtask

    always @(negedge clk) begin
        if (rst && o_frame_valid && i_frame_ready) begin
            if (sb.size() == 0) check("unexpected_frame_valid", o_frame_valid, 0);
            else check("frame", {15'd0, o_frame_last, o_frame}, {15'd0, sb.pop_front()});
        end
    end

    initial begin
        logic [63:0] rb;
        do_reset();
        // Rate 1/2 eight bits, no last.
        sb.push_back({1'b0, 16'hE17E});
        send_msg(64'h4D, 8, CODE_RATE_2, 1'b0, 1'b0, 1'b0);
        drain("drain_e17e");
        // Backpressure held for 5 cycles in EMIT.
        do_reset();
        i_frame_ready = 1'b0;
        sb.push_back({1'b0, 16'hE17E});
        send_msg(64'h4D, 8, CODE_RATE_2, 1'b0, 1'b0, 1'b0);
        check("fill_to_valid_latency", o_frame_valid, 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_frame", o_frame, 16'hE17E);
            check("bp_valid", o_frame_valid, 1);
            check("bp_bit_ready", o_bit_ready, 0);
        end
        @(posedge clk);
        #1 i_frame_ready = 1'b1;
        @(negedge clk);
        drain("drain_bp");
        // Single-bit messages; rate is released between them.
        do_reset();
        sb.push_back({1'b1, 16'hEC00});
        send_bit(1'b1, 1'b1, CODE_RATE_2);
        drain("drain_ec00");
        check("idle_bit_ready", o_bit_ready, 1);
        sb.push_back({1'b1, 16'hF700});
        send_bit(1'b1, 1'b1, CODE_RATE_3);
        drain("drain_f700");
        // 7 bits at 1/2: first tail fills frame 1, second tail alone in frame 2.
        do_reset();
        send_msg(64'h4D, 7, CODE_RATE_2, 1'b1, 1'b0, 1'b1);
        drain("drain_7bit");
        // Final tail fills the frame exactly at both rates, then fill during FLUSH.
        do_reset();
        send_msg(64'h2B, 6, CODE_RATE_2, 1'b1, 1'b0, 1'b1);
        drain("drain_exact_r2");
        send_msg(64'h5, 3, CODE_RATE_3, 1'b1, 1'b0, 1'b1);
        drain("drain_exact_r3");
        send_msg(64'h9, 4, CODE_RATE_3, 1'b1, 1'b0, 1'b1);
        drain("drain_flush_fill");
        // Mid-message rate changes and a stray i_last without valid are ignored.
        do_reset();
        send_msg(64'hB3D, 12, CODE_RATE_2, 1'b1, 1'b1, 1'b1);
        drain("drain_rate_hold");
        rb = {$urandom, $urandom};
        send_msg(rb, 20, CODE_RATE_3, 1'b1, 1'b1, 1'b1);
        drain("drain_rand_r3");
        // Reset mid-frame discards the partial frame.
        do_reset();
        send_msg(64'h5, 3, CODE_RATE_2, 1'b0, 1'b0, 1'b0);
        do_reset();
        repeat (3) @(negedge clk);
        check("after_mid_reset_valid", o_frame_valid, 0);
        sb.push_back({1'b0, 16'hE17E});
        send_msg(64'h4D, 8, CODE_RATE_2, 1'b0, 1'b0, 1'b0);
        drain("drain_after_reset");
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/conv_encoder_framer.md
CONV_ENCODER_FRAMER -- requirements
Module: conv_encoder_framer

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: rising-edge clock.
REQ-002 The block SHALL have the port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-003 The block SHALL have the port i_code_rate, input, 1 bit: code rate select, CODE_RATE_2 (1/2) or CODE_RATE_3 (1/3).
REQ-004 The block SHALL have the port i_bit, input, 1 bit: message bit.
REQ-005 The block SHALL have the port i_bit_valid, input, 1 bit: i_bit is valid.
REQ-006 The block SHALL have the port i_last, input, 1 bit: qualifies i_bit as the final bit of the message.
REQ-007 The block SHALL have the port o_bit_ready, output, 1 bit: the block accepts i_bit in this cycle.
REQ-008 The block SHALL have the port o_frame, output, 16 bits: packed encoded frame, MSB first.
REQ-009 The block SHALL have the port o_frame_valid, output, 1 bit: o_frame holds a complete frame.
REQ-010 The block SHALL have the port o_frame_last, output, 1 bit: the current frame ends the message.
REQ-011 The block SHALL have the port i_frame_ready, input, 1 bit: the downstream accepts o_frame.

Function
REQ-012 A bit SHALL be accepted on a cycle with i_bit_valid=1 and o_bit_ready=1.
REQ-013 A frame SHALL be transferred on a cycle with o_frame_valid=1 and i_frame_ready=1.
REQ-014 The encoder SHALL be K=3 with state {s1,s0}, where s1 is the most recent bit; the state SHALL update to s1<=b and s0<=s1 on each encoded bit b.
REQ-015 At rate 1/2 the symbol SHALL be {b^s1^s0, b^s0} (generators 7,5 octal).
REQ-016 At rate 1/3 the symbol SHALL be {b^s1^s0, b^s0, b^s1} (generators 7,5,6 octal).
REQ-017 Symbols SHALL be packed from bit 15 downward.
REQ-018 A frame SHALL hold 8 symbols at rate 1/2, or 5 symbols plus bit0=0 at rate 1/3.
REQ-019 The FSM SHALL have the states IDLE, ENC, FLUSH and EMIT.
REQ-020 In IDLE, o_bit_ready SHALL be 1.
REQ-021 The first accepted bit SHALL latch i_code_rate for the whole message; changes to i_code_rate mid-message SHALL be ignored.
REQ-022 In ENC, o_bit_ready SHALL be 1, and each accepted bit SHALL write one symbol and increment the 4-bit symbol count.
REQ-023 A bit accepted with i_last=1 SHALL be encoded, and the FSM SHALL then enter FLUSH.
REQ-024 FLUSH SHALL encode two zero tail bits, one per cycle, with o_bit_ready=0.
REQ-025 When a symbol fills the frame, the FSM SHALL enter EMIT on the next cycle with o_frame_valid=1; the latency from the filling write to valid SHALL be 1 cycle.
REQ-026 In EMIT, o_bit_ready SHALL be 0, and o_frame and o_frame_last SHALL be held stable until transfer.
REQ-027 On transfer, the block SHALL clear the frame and count, then return to ENC, or to FLUSH if tail bits remain, or to IDLE if the frame was last.
REQ-028 After the second tail bit, the partial frame SHALL be emitted zero-padded with o_frame_last=1, the state SHALL be cleared to 00, and the latched rate SHALL be released.
REQ-029 If the frame fills during FLUSH, the block SHALL emit it with o_frame_last=0 and SHALL resume FLUSH after transfer.
REQ-030 A frame filled exactly by the final tail bit SHALL be emitted with o_frame_last=1, and no empty frame SHALL follow.
REQ-031 i_last with i_bit_valid=0 SHALL be ignored.

Reset
REQ-032 When rst=0, the block SHALL enter IDLE and set state=00, count=0, o_frame=0, o_frame_valid=0 and o_frame_last=0, with o_bit_ready=1 after deassertion.
REQ-033 Reset asserted mid-frame SHALL discard the partial frame with no output.

Structure
REQ-034 CODE_RATE_2, CODE_RATE_3, the generator constants and the FSM state enum SHALL reside in the shared param_def definitions.
REQ-035 A combinational sub-module conv_symbol_gen (inputs b, s1, s0, rate; output 3-bit symbol) SHALL be instantiated once.

Verification
REQ-036 Rate 1/2, bits 1,0,1,1,0,0,1,0 from reset with no i_last -> o_frame=16'hE17E and o_frame_last=0.
REQ-037 Rate 1/2, single bit 1 with i_last=1 -> o_frame=16'hEC00 and o_frame_last=1, then the block returns to IDLE.
REQ-038 Rate 1/3, single bit 1 with i_last=1 -> o_frame=16'hF700 and o_frame_last=1.
REQ-039 Backpressure: with i_frame_ready=0 for 5 cycles while in EMIT, o_frame and o_frame_valid SHALL stay stable and o_bit_ready SHALL stay 0.
REQ-040 Rate 1/2, 7 bits with the 7th i_last -> frame 1 (8 symbols, incl. tail 1) has last=0, and frame 2 holds 1 tail symbol with last=1.
REQ-041 Reset pulsed after 3 accepted bits -> no frame is emitted, and a subsequent 8-bit sequence reproduces the REQ-036 result.
